// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (SYNC, length, hi/lo word
// pairs, XOR checksum) and writes it into instruction memory. The downstream
// CPU is held in reset until a complete frame has been loaded and verified.
module program_loader #(
   parameter int          ADDR_W    = 8,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      CSUM,
      DONE,
      ERR
   } state_t;

   // Largest word count that fits in the instruction-memory address space.
   localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

   state_t              state_q,      state_d;
   logic [7:0]          words_left_q, words_left_d;
   logic [ADDR_W-1:0]   index_q,      index_d;
   logic [7:0]          hi_q,         hi_d;
   logic [7:0]          csum_q,       csum_d;
   logic                rx_ready_q,   rx_ready_d;
   logic                imem_we_q,    imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
   logic [15:0]         imem_wdata_q, imem_wdata_d;
   logic                cpu_reset_q,  cpu_reset_d;
   logic                load_done_q,  load_done_d;
   logic                load_error_q, load_error_d;

   logic                accept;

   // A byte transfers only when both sides of the handshake agree this cycle.
   assign accept = rx_valid && rx_ready_q;

   // Next-state and next-output decode for the frame parser.
   always_comb begin
      // NOTE: every variable gets a default here so no path can infer a latch.
      state_d      = state_q;
      words_left_d = words_left_q;
      index_d      = index_q;
      hi_d         = hi_q;
      csum_d       = csum_q;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      imem_we_d    = 1'b0;
      rx_ready_d   = 1'b1;

      if (accept) begin
         unique case (state_q)
            IDLE, DONE, ERR: begin
               // Anything other than the marker is discarded.
               if (rx_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
               words_left_d = rx_data;
               index_d      = '0;
               csum_d       = '0;
               if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) state_d = ERR;
               else                                              state_d = HI;
            end
            HI: begin
               hi_d    = rx_data;
               csum_d  = csum_q ^ rx_data;
               state_d = LO;
            end
            LO: begin
               // Write strobe is issued next cycle; the loader stalls input
               // for exactly that cycle.
               imem_we_d    = 1'b1;
               rx_ready_d   = 1'b0;
               imem_addr_d  = index_q;
               imem_wdata_d = {hi_q, rx_data};
               index_d      = index_q + ADDR_W'(1);
               csum_d       = csum_q ^ rx_data;
               words_left_d = words_left_q - 8'd1;
               state_d      = (words_left_q == 8'd1) ? CSUM : HI;
            end
            CSUM: begin
               state_d = (rx_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
         endcase
      end

      // Status outputs follow the state being entered so they change on the
      // same edge as the state itself.
      cpu_reset_d  = (state_d != DONE);
      load_done_d  = (state_d == DONE);
      load_error_d = (state_d == ERR);
   end

   // Frame-parser state and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         index_q      <= '0;
         hi_q         <= '0;
         csum_q       <= '0;
         rx_ready_q   <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         state_q      <= state_d;
         words_left_q <= words_left_d;
         index_q      <= index_d;
         hi_q         <= hi_d;
         csum_q       <= csum_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: drives byte frames through the
// valid/ready handshake and checks memory writes and status outputs against
// hand-computed values.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   // Narrow-address instance used only for the word-count limit.
   logic        s_rx_ready;
   logic        s_imem_we;
   logic [1:0]  s_imem_addr;
   logic [15:0] s_imem_wdata;
   logic        s_cpu_reset;
   logic        s_load_done;
   logic        s_load_error;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int hs_viol  = 0;
   logic [15:0] mem [0:255];

   program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   program_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5)) u_small (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (s_rx_ready),
      .imem_we    (s_imem_we),
      .imem_addr  (s_imem_addr),
      .imem_wdata (s_imem_wdata),
      .cpu_reset  (s_cpu_reset),
      .load_done  (s_load_done),
      .load_error (s_load_error)
   );

   always #5 clk = ~clk;

   // Record every memory write the DUT issues.
   always @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wr_cnt         <= wr_cnt + 1;
      end
   end

   // rx_ready must be the exact complement of imem_we on every cycle.
   always @(negedge clk) begin
      if (!reset && (rx_ready == imem_we)) hs_viol <= hs_viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte and return at the negedge after it has transferred.
   task automatic send(input logic [7:0] b);
      int waited = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      rx_valid = 1'b0;
      rx_data  = 8'h5A;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   int base;

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      check("rst_flags", {27'd0, rx_ready, imem_we, cpu_reset, load_done, load_error}, 32'b10100);
      check("rst_addr",  {24'd0, imem_addr}, 32'd0);
      check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Frame A5,02,10,05,20,0A,3F
      send(8'hA5); send(8'h02);
      check("len_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      send(8'h10); send(8'h05); send(8'h20); send(8'h0A);
      check("a_before_csum_done", {31'd0, load_done}, 32'd0);
      send(8'h3F);
      check("a_wr_cnt", wr_cnt, 32'd2);
      check("a_mem0", {16'd0, mem[0]}, 32'h1005);
      check("a_mem1", {16'd0, mem[1]}, 32'h200A);
      check("a_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b010);
      check("a_hold_addr",  {24'd0, imem_addr}, 32'd1);
      check("a_hold_wdata", {16'd0, imem_wdata}, 32'h200A);

      // Same frame from DONE with a bad checksum
      send(8'hA5);
      check("b_restart_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b100);
      send(8'h02); send(8'h10); send(8'h05); send(8'h20); send(8'h0A);
      send(8'h00);
      check("b_wr_cnt", wr_cnt, 32'd4);
      check("b_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b101);

      // Leading junk in IDLE, then a single-word frame
      do_reset();
      send(8'h00); send(8'hFF);
      check("c_junk_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b100);
      send(8'hA5); send(8'h01); send(8'hF0); send(8'h00); send(8'hF0);
      check("c_wr_cnt", wr_cnt, 32'd5);
      check("c_mem0", {16'd0, mem[0]}, 32'hF000);
      check("c_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b010);

      // Zero-length frame
      send(8'hA5); send(8'h00);
      check("d_wr_cnt", wr_cnt, 32'd5);
      check("d_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b101);

      // Word count limit on a 4-word address space: 5 rejected, 4 accepted
      do_reset();
      send(8'hA5); send(8'h05);
      check("lim5_small_err", {31'd0, s_load_error}, 32'd1);
      check("lim5_main_err",  {31'd0, load_error}, 32'd0);
      do_reset();
      send(8'hA5); send(8'h04);
      check("lim4_small_err", {31'd0, s_load_error}, 32'd0);
      do_reset();

      // Valid frame with a gap before every byte
      base = wr_cnt;
      idle_cycle(); send(8'hA5);
      idle_cycle(); send(8'h02);
      idle_cycle(); send(8'h10);
      idle_cycle(); send(8'h05);
      idle_cycle(); send(8'h20);
      idle_cycle(); send(8'h0A);
      idle_cycle(); send(8'h3F);
      check("e_wr_cnt", wr_cnt - base, 32'd2);
      check("e_mem0", {16'd0, mem[0]}, 32'h1005);
      check("e_mem1", {16'd0, mem[1]}, 32'h200A);
      check("e_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b010);

      // Reset after the HI byte of word 1
      do_reset();
      mem[1] = 16'hDEAD;
      base   = wr_cnt;
      send(8'hA5); send(8'h02); send(8'h10); send(8'h05); send(8'h20);
      reset = 1'b1;
      #1;
      check("f_rst_flags", {27'd0, rx_ready, imem_we, cpu_reset, load_done, load_error}, 32'b10100);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(8'h0A); send(8'h3F);
      check("f_wr_cnt", wr_cnt - base, 32'd1);
      check("f_mem1_untouched", {16'd0, mem[1]}, 32'hDEAD);
      check("f_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b100);
      send(8'hA5); send(8'h01); send(8'hF0); send(8'h00); send(8'hF0);
      check("f_done_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b010);
      send(8'hA5);
      check("f_restart_flags", {29'd0, cpu_reset, load_done, load_error}, 32'b100);

      check("handshake_violations", hs_viol, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  incoming serial byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a byte.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid and rx_ready are both high on a rising edge.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port imem_addr  output  ADDR_W  word address for the write.
REQ-010 SHALL have port imem_wdata  output  16  instruction word for the write.
REQ-011 SHALL have port cpu_reset  output  1  active-high hold-in-reset for the downstream CPU.
REQ-012 SHALL have port load_done  output  1  last frame loaded and verified.
REQ-013 SHALL have port load_error  output  1  last frame rejected.

Function
REQ-014 SHALL implement FSM states IDLE, LEN, HI, LO, CSUM, DONE, ERR; all outputs registered.
REQ-015 SHALL drive rx_ready high in every state except for the single cycle in which imem_we is high.
REQ-016 IDLE: accepted SYNC_BYTE -> LEN; any other byte discarded, state unchanged.
REQ-017 LEN: accepted byte N stored as word count; N=0 -> ERR; else word index and checksum cleared, -> HI.
REQ-018 HI: accepted byte stored as word[15:8], -> LO.
REQ-019 LO: accepted byte forms word {hi,lo}; next cycle imem_we=1, imem_addr=word index, imem_wdata=word; word index then increments; -> HI if fewer than N words written, else -> CSUM.
REQ-020 SHALL compute checksum as 8-bit XOR of all HI/LO data bytes only (SYNC and length bytes excluded).
REQ-021 CSUM: accepted byte equal to checksum -> DONE; unequal -> ERR.
REQ-022 SHALL hold cpu_reset=1 in all states except DONE; cpu_reset drops on the same edge the FSM enters DONE.
REQ-023 load_done=1 only in DONE; load_error=1 only in ERR; both 0 elsewhere.
REQ-024 DONE or ERR: accepted SYNC_BYTE -> LEN, cpu_reset reasserted and load_done/load_error cleared on that edge; other bytes discarded.
REQ-025 Bytes arriving while rx_ready=0 SHALL not be consumed; rx_valid low cycles SHALL stall the FSM with no state change.
REQ-026 Word index SHALL be ADDR_W bits; N greater than 2^ADDR_W -> ERR at LEN.
REQ-027 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-028 On reset: state IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word count, index and checksum 0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; already-written memory words are not cleared; no further imem_we until a new frame.

Verification
REQ-030 Frame A5,02,10,05,20,0A,3F -> writes addr0=0x1005, addr1=0x200A; load_done=1, cpu_reset=0 after checksum byte.
REQ-031 Same frame with checksum 0x00 -> two writes occur, load_error=1, cpu_reset stays 1.
REQ-032 Bytes 00,FF then A5,01,F0,00,F0 -> leading bytes ignored; addr0=0xF000; load_done=1.
REQ-033 Frame A5,00 -> load_error=1, no imem_we.
REQ-034 Valid frame with rx_valid toggled low between every byte -> identical writes and completion as REQ-030.
REQ-035 Reset asserted after HI byte of word 1 -> state IDLE, cpu_reset=1, no write to addr1; subsequent A5 in DONE restarts with cpu_reset=1.
